fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 4: data bits per serial frame; SHALL equal the read width of the upstream FIFO.
REQ-002 Parameter DVSR, default 651: system clocks per oversample tick (100 MHz / (9600 baud * 16)).
REQ-003 Parameter SB_TICK, default 16: oversample ticks in the stop period (16 gives one stop bit, 24 gives 1.5, 32 gives 2).
REQ-004 clk  input  1  system clock; one clock domain, all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 empty  input  1  upstream FIFO empty flag.
REQ-007 r_data  input  DATA_WIDTH  upstream FIFO head word, valid whenever empty=0 (first-word-fall-through).
REQ-008 rd  output  1  FIFO pop strobe; one-cycle pulse per word consumed.
REQ-009 tx  output  1  serial line; idle high, LSB first.
REQ-010 tx_busy  output  1  high in every state except IDLE.
REQ-011 tx_done_tick  output  1  one-cycle pulse on the last stop-period tick of each frame.

Function
REQ-012 The tick counter SHALL count 0..DVSR-1 with width $clog2(DVSR), be held at 0 in IDLE, and assert s_tick when it equals DVSR-1, then wrap to 0.
REQ-013 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-014 IDLE: when empty=0, assert rd combinationally in that same cycle, load r_data into the shift register, clear the tick and bit counters, and go to START; when empty=1, stay in IDLE with rd=0.
REQ-015 rd SHALL equal (state==IDLE) && !empty && !reset; rd SHALL never assert in any other state or while reset=1.
REQ-016 START: hold tx=0; on the 16th s_tick, clear the tick count and go to DATA.
REQ-017 DATA: tx = shift register bit 0; on every 16th s_tick, shift right by one and increment the bit count; after DATA_WIDTH bits, go to STOP.
REQ-018 STOP: hold tx=1; on the SB_TICK-th s_tick, pulse tx_done_tick and go to IDLE.
REQ-019 tx SHALL be registered and glitch-free.
REQ-020 Each data bit SHALL last exactly 16*DVSR cycles.
REQ-021 Timing from the rd cycle to tx_done_tick:
  - tx falls on the cycle after the rd cycle;
  - a frame lasts exactly (16*(1+DATA_WIDTH)+SB_TICK)*DVSR cycles from that tx fall;
  - tx_done_tick asserts in the last cycle of the frame.
REQ-022 Back-to-back frames: after STOP, one IDLE cycle with tx=1 SHALL occur before the next rd, so the inter-frame gap is exactly 1 clock.
REQ-023 The shift register SHALL hold its captured copy; changes on r_data or empty during START, DATA or STOP SHALL not affect the frame in progress.
REQ-024 tx_busy and tx_done_tick SHALL be decoded from registered state only (no combinational path from empty or r_data).

Reset
REQ-025 While reset=1 at a rising edge:
  - state becomes IDLE;
  - the tick counter, bit counter and shift register clear to 0;
  - tx becomes 1;
  - rd, tx_busy and tx_done_tick are 0 from the next cycle.
REQ-026 Reset mid-frame SHALL abort the frame, drive tx=1 from the following cycle, and issue no tx_done_tick for the aborted word; the popped word is lost.
REQ-027 After reset deasserts with empty=0, the first rd SHALL occur in the first cycle with reset=0.

Verification (DATA_WIDTH=4, DVSR=2, SB_TICK=16: bit period 32 cycles, frame 192 cycles)
REQ-028 Single word: r_data=4'b0110, empty=0 for one IDLE cycle.
  - rd pulses once.
  - tx sequence is 0,0,1,1,0,1, each level held 32 cycles.
  - tx_done_tick pulses at cycle 192 after the tx fall.
REQ-029 FIFO empty: empty=1 for 500 cycles -> rd=0, tx=1, tx_busy=0 throughout.
REQ-030 Back-to-back: 9 words 4'h0,4'hF,4'h6,4'h9,4'h5,4'hA,4'h2,4'hD,4'hF queued ->
  - exactly 9 rd pulses, each 193 cycles apart;
  - decoded nibbles match the queued order.
REQ-031 r_data changed to 4'hF and empty toggled during DATA of a 4'h3 frame -> frame still decodes 4'h3 and no extra rd occurs.
REQ-032 Reset asserted 70 cycles into a frame ->
  - tx=1 and tx_busy=0 on the next cycle;
  - no tx_done_tick for that frame;
  - the next frame starts cleanly after release.
REQ-033 Integrated with the 8-in/4-out asymmetric FIFO: write 8'hF0 then 8'h96 ->
  - four frames, each nibble in the FIFO's defined read order;
  - empty=1 after the 4th rd.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side link between a first-word-fall-through FIFO and its consumer.
// The master pops words (drives rd); the slave is the FIFO presenting its head word.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  rd;

  modport master (
    input  empty,
    input  r_data,
    output rd
  );

  modport slave (
    output empty,
    output r_data,
    input  rd
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed straight from a FWFT FIFO.
// Pops one word per frame, sends start bit, DATA_WIDTH data bits LSB first,
// then a stop period of SB_TICK oversample ticks (16 ticks per bit).
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 4,
  parameter int DVSR       = 651,
  parameter int SB_TICK    = 16
) (
  input  logic              clk,
  input  logic              reset,
  fifo_uart_tx_if.master    fifo,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  // Counter widths; guards keep degenerate parameter values from producing 0-bit vectors.
  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(DVSR - 1);
  localparam logic [SW-1:0] S_BIT_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_reg;
  logic [TW-1:0]         tick_reg;
  logic [SW-1:0]         s_reg;
  logic [NW-1:0]         n_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  tx_reg;
  logic                  s_tick;
  logic [DATA_WIDTH-1:0] b_shift;

  assign s_tick  = (tick_reg == TICK_LAST);
  assign b_shift = b_reg >> 1;

  // The pop must land in the same cycle the head word is captured, so rd is
  // the only output decoded from live inputs; reset masks it immediately.
  assign fifo.rd = (state_reg == IDLE) && !fifo.empty && !reset;

  // Status outputs come from registered state and counters only.
  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = (state_reg == STOP) && s_tick && (s_reg == S_STOP_LAST);

  // Oversample tick generator: parked at 0 while idle so every frame starts phase-aligned.
  always_ff @(posedge clk) begin
    if (reset || state_reg == IDLE) begin
      tick_reg <= '0;
    end else if (s_tick) begin
      tick_reg <= '0;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  // Frame sequencer; tx is updated on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo.empty) begin
            b_reg     <= fifo.r_data;
            s_reg     <= '0;
            n_reg     <= '0;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == S_BIT_LAST) begin
              s_reg     <= '0;
              tx_reg    <= b_reg[0];
              state_reg <= DATA;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == S_BIT_LAST) begin
              s_reg <= '0;
              b_reg <= b_shift;
              if (n_reg == N_LAST) begin
                tx_reg    <= 1'b1;
                state_reg <= STOP;
              end else begin
                n_reg  <= n_reg + 1'b1;
                tx_reg <= b_shift[0];
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_reg == S_STOP_LAST) begin
              s_reg     <= '0;
              state_reg <= IDLE;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FWFT FIFO model feeding the DUT, a serial-line
// monitor that checks every cycle of each frame against a scoreboard entry.
module tb_fifo_uart_tx;

  localparam int DW    = 4;
  localparam int DVSR  = 2;
  localparam int SB    = 16;
  localparam int BIT   = 16 * DVSR;                    // 32 cycles
  localparam int FRAME = (16 * (1 + DW) + SB) * DVSR;  // 192 cycles

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy, tx_done_tick;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

  fifo_uart_tx #(
    .DATA_WIDTH(DW),
    .DVSR      (DVSR),
    .SB_TICK   (SB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo        (fif),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [5:0] levels;     // bit k = line level during bit period k (start..stop)
    int         rd_pulses;
  } vec_t;

  vec_t tv[6];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0] fifo_q[$];
  logic [5:0] exp_q[$];
  int         rd_cycq[$];

  int   rd_count = 0;
  int   last_rd_cyc = -10;
  int   frames_done = 0;
  int   done_count = 0;
  bit   pop_req = 0;
  bit   ovr = 0;

  bit         in_frame = 0;
  int         fc = 0;
  int         ferr = 0;
  logic [5:0] cur_exp = '0;
  logic [5:0] mid = '0;

  function automatic logic [5:0] lvl(input logic [3:0] n);
    return {1'b1, n, 1'b0};
  endfunction

  task automatic check(input string nm, input int got, input int expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, expv, expv);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", (frames_done >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (rd_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rd_timeout", (rd_count >= target) ? 1 : 0, 1);
  endtask

  task automatic push_word(input logic [3:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(lvl(w));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO model: pops after the edge that consumed the head word.
  always @(posedge clk) begin
    #1;
    if (pop_req) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_req = 0;
    end
    if (!ovr) begin
      fif.empty  = (fifo_q.size() == 0);
      fif.r_data = (fifo_q.size() > 0) ? fifo_q[0] : 4'h0;
    end
  end

  // Line monitor: checks every cycle of a frame against the expected levels.
  always @(negedge clk) begin
    if (fif.rd === 1'b1) begin
      rd_count++;
      last_rd_cyc = cyc;
      rd_cycq.push_back(cyc);
      pop_req = 1;
    end
    if (tx_done_tick === 1'b1) done_count++;
    if (reset) begin
      in_frame = 0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1;
        fc = 0;
        ferr = 0;
        mid = '0;
        check("rd_to_fall", cyc - last_rd_cyc, 1);
        if (exp_q.size() == 0) begin
          check("frame_expected", 0, 1);
          cur_exp = '0;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (in_frame) begin
        if (tx !== cur_exp[fc / BIT]) ferr++;
        if (tx_busy !== 1'b1) ferr++;
        if (tx_done_tick !== (fc == FRAME - 1)) ferr++;
        if (fc % BIT == BIT / 2) mid[fc / BIT] = tx;
        fc++;
        if (fc == FRAME) begin
          in_frame = 0;
          frames_done++;
          check("frame_wave_errs", ferr, 0);
          check("frame_levels", int'(mid), int'(cur_exp));
          $display("[TB] frame %0d data=%h levels=%b expected=%b", frames_done, mid[4:1], mid, cur_exp);
        end
      end
    end
  end

  initial begin
    int base;
    int dbase;
    int bad;
    int n;

    tv[0] = '{data: 4'b0110, levels: 6'b101100, rd_pulses: 1};
    tv[1] = '{data: 4'h0,    levels: 6'b100000, rd_pulses: 1};
    tv[2] = '{data: 4'hF,    levels: 6'b111110, rd_pulses: 1};
    tv[3] = '{data: 4'hA,    levels: 6'b110100, rd_pulses: 1};
    tv[4] = '{data: 4'h1,    levels: 6'b100010, rd_pulses: 1};
    tv[5] = '{data: 4'h8,    levels: 6'b110000, rd_pulses: 1};

    reset = 1'b1;
    fif.empty = 1'b1;
    fif.r_data = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done_tick, 0);
    check("reset_rd", fif.rd, 0);

    // Empty FIFO for 500 cycles
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (fif.rd !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("idle_500", bad, 0);
    $display("[TB] idle 500 cycles, violations=%0d", bad);

    // Single-word frames from the vector table
    for (int i = 0; i < 6; i++) begin
      base = rd_count;
      fifo_q.push_back(tv[i].data);
      exp_q.push_back(tv[i].levels);
      wait_frames(frames_done + 1, 400);
      check("rd_once", rd_count - base, tv[i].rd_pulses);
      repeat (5) @(negedge clk);
    end

    // Back-to-back: nine queued words
    rd_cycq.delete();
    base = rd_count;
    push_word(4'h0); push_word(4'hF); push_word(4'h6);
    push_word(4'h9); push_word(4'h5); push_word(4'hA);
    push_word(4'h2); push_word(4'hD); push_word(4'hF);
    wait_frames(frames_done + 9, 9 * 200);
    check("b2b_rd_count", rd_count - base, 9);
    if (rd_cycq.size() >= 9) begin
      for (int k = 1; k < 9; k++) check("b2b_gap", rd_cycq[k] - rd_cycq[k-1], 193);
    end else begin
      check("b2b_rd_log", rd_cycq.size(), 9);
    end
    repeat (5) @(negedge clk);

    // Input disturbance during DATA of a 4'h3 frame
    base = rd_count;
    push_word(4'h3);
    wait_rd(base + 1, 50);
    repeat (60) @(negedge clk);
    ovr = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      fif.r_data = 4'hF;
      fif.empty = k[0];
    end
    fif.empty = 1'b1;
    ovr = 0;
    wait_frames(frames_done + 1, 300);
    check("no_extra_rd", rd_count - base, 1);
    repeat (5) @(negedge clk);

    // Reset 70 cycles into a frame, with the next word already waiting
    base = rd_count;
    push_word(4'h5);
    wait_rd(base + 1, 50);
    n = 0;
    while (!(in_frame && fc >= 70) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_70", (in_frame && fc >= 70) ? 1 : 0, 1);
    exp_q.delete();
    fifo_q.push_back(4'h9);
    exp_q.push_back(lvl(4'h9));
    dbase = done_count;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("rd_in_reset", fif.rd, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rd_first_after_reset", fif.rd, 1);
    wait_frames(frames_done + 1, 300);
    check("done_after_abort", done_count - dbase, 1);
    $display("[TB] reset abort: done pulses since abort=%0d", done_count - dbase);
    repeat (5) @(negedge clk);

    // 8-in/4-out FIFO: each byte reads out low nibble first
    base = rd_count;
    dbase = frames_done;
    push_word(4'h0); push_word(4'hF);   // byte 8'hF0
    push_word(4'h6); push_word(4'h9);   // byte 8'h96
    wait_rd(base + 4, 4 * 200);
    @(negedge clk);
    check("empty_after_4th", fif.empty, 1);
    wait_frames(dbase + 4, 400);
    check("asym_rd_count", rd_count - base, 4);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
